// File: rtl/mha_qk_score_if.sv
// Purpose : handshake bundle for mha_qk_score (control, Q stream, K stream, Z stream).
// Ports   : master = Q/K producer + Z consumer side, slave = the score engine.
//           init/n_tok/ready/done   pass control
//           q_valid/q_data/q_ready  query row elements
//           k_valid/k_data/k_ready  key row elements, row-major
//           z_valid/z_data/z_last/z_ready  scaled, saturated scores
interface mha_qk_score_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned N_TOK  = 197
);
    localparam int unsigned N_W = $clog2(N_TOK + 1);

    logic                     init;
    logic [N_W-1:0]           n_tok;
    logic                     ready;
    logic                     done;

    logic                     q_valid;
    logic signed [DATA_W-1:0] q_data;
    logic                     q_ready;

    logic                     k_valid;
    logic signed [DATA_W-1:0] k_data;
    logic                     k_ready;

    logic                     z_valid;
    logic signed [OUT_W-1:0]  z_data;
    logic                     z_last;
    logic                     z_ready;

    modport master (
        output init, n_tok, q_valid, q_data, k_valid, k_data, z_ready,
        input  ready, done, q_ready, k_ready, z_valid, z_data, z_last
    );

    modport slave (
        input  init, n_tok, q_valid, q_data, k_valid, k_data, z_ready,
        output ready, done, q_ready, k_ready, z_valid, z_data, z_last
    );
endinterface

// File: rtl/mha_qk_score.sv
// Purpose : one attention head's compatibility row. Buffers a query row Q[i], then for
//           each of n streamed key rows K[j] emits sat((Q[i].K[j]) >>> SCALE_SHIFT).
// Ports   : clk      clock
//           reset_n  synchronous active-low reset
//           bus      mha_qk_score_if.slave (control, Q in, K in, Z out)
module mha_qk_score #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned D_H         = 64,
    parameter int unsigned N_TOK       = 197,
    parameter int unsigned OUT_W       = 16,
    parameter int unsigned SCALE_SHIFT = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    mha_qk_score_if.slave   bus
);
    localparam int unsigned IDX_W  = $clog2(D_H);
    localparam int unsigned N_W    = $clog2(N_TOK + 1);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = PROD_W + $clog2(D_H);
    localparam int unsigned CMP_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(D_H - 1);
    localparam logic [N_W-1:0]          N_MAX    = N_W'(N_TOK);
    localparam logic signed [CMP_W-1:0] Z_MAX    = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] Z_MIN    = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_Q,
        S_MAC,
        S_OUT,
        S_DONE
    } state_t;

    state_t                    r_state;
    logic                      r_ready;
    logic                      r_done;
    logic                      r_q_ready;
    logic                      r_k_ready;
    logic                      r_z_valid;
    logic                      r_z_last;
    logic signed [OUT_W-1:0]   r_z_data;
    logic [N_W-1:0]            r_n_lat;
    logic [N_W-1:0]            r_row;
    logic [IDX_W-1:0]          r_q_idx;
    logic [IDX_W-1:0]          r_e_idx;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [DATA_W-1:0]  r_q_buf [D_H];

    logic [N_W-1:0]            w_n_clamp;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [ACC_W-1:0]   w_shift;
    logic signed [CMP_W-1:0]   w_ext;
    logic signed [OUT_W-1:0]   w_sat;

    // Requested row count, limited to what a pass supports.
    assign w_n_clamp = (bus.n_tok > N_MAX) ? N_MAX : bus.n_tok;

    // Accumulator including the current K beat; the score is formed from this on the
    // last beat so z_data is already registered when OUT is entered.
    assign w_prod     = r_q_buf[r_e_idx] * bus.k_data;
    assign w_acc_next = r_acc + ACC_W'(w_prod);
    assign w_shift    = w_acc_next >>> SCALE_SHIFT;
    assign w_ext      = CMP_W'(w_shift);

    // Clamp the floored, scaled dot product to the signed output range.
    always_comb begin
        w_sat = w_ext[OUT_W-1:0];
        if (w_ext > Z_MAX) begin
            w_sat = Z_MAX[OUT_W-1:0];
        end else if (w_ext < Z_MIN) begin
            w_sat = Z_MIN[OUT_W-1:0];
        end
    end

    // Query buffer has no reset: it is always fully rewritten before being read.
    always_ff @(posedge clk) begin
        if (r_q_ready && bus.q_valid) begin
            r_q_buf[r_q_idx] <= bus.q_data;
        end
    end

    // Pass sequencer; handshake outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_q_ready <= 1'b0;
            r_k_ready <= 1'b0;
            r_z_valid <= 1'b0;
            r_z_last  <= 1'b0;
            r_z_data  <= '0;
            r_n_lat   <= '0;
            r_row     <= '0;
            r_q_idx   <= '0;
            r_e_idx   <= '0;
            r_acc     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.init) begin
                        r_n_lat <= w_n_clamp;
                        r_ready <= 1'b0;
                        if (w_n_clamp == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_LOAD_Q;
                            r_q_ready <= 1'b1;
                            r_q_idx   <= '0;
                        end
                    end
                end

                S_LOAD_Q: begin
                    if (bus.q_valid) begin
                        if (r_q_idx == LAST_IDX) begin
                            r_state   <= S_MAC;
                            r_q_ready <= 1'b0;
                            r_k_ready <= 1'b1;
                            r_q_idx   <= '0;
                            r_acc     <= '0;
                            r_e_idx   <= '0;
                            r_row     <= '0;
                        end else begin
                            r_q_idx <= r_q_idx + IDX_W'(1);
                        end
                    end
                end

                S_MAC: begin
                    if (bus.k_valid) begin
                        r_acc <= w_acc_next;
                        if (r_e_idx == LAST_IDX) begin
                            r_state   <= S_OUT;
                            r_k_ready <= 1'b0;
                            r_z_valid <= 1'b1;
                            r_z_data  <= w_sat;
                            r_z_last  <= (r_row == r_n_lat - N_W'(1));
                            r_e_idx   <= '0;
                        end else begin
                            r_e_idx <= r_e_idx + IDX_W'(1);
                        end
                    end
                end

                S_OUT: begin
                    if (bus.z_ready) begin
                        r_z_valid <= 1'b0;
                        r_z_last  <= 1'b0;
                        if (r_z_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_MAC;
                            r_k_ready <= 1'b1;
                            r_row     <= r_row + N_W'(1);
                            r_acc     <= '0;
                            r_e_idx   <= '0;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_ready   <= 1'b1;
                    r_q_ready <= 1'b0;
                    r_k_ready <= 1'b0;
                    r_z_valid <= 1'b0;
                    r_z_last  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready   = r_ready;
    assign bus.done    = r_done;
    assign bus.q_ready = r_q_ready;
    assign bus.k_ready = r_k_ready;
    assign bus.z_valid = r_z_valid;
    assign bus.z_data  = r_z_data;
    assign bus.z_last  = r_z_last;
endmodule

// File: tb/tb_mha_qk_score.sv
// Purpose : directed bench for mha_qk_score (D_H=4, DATA_W=8, OUT_W=16, N_TOK=8).
//           dut0 uses SCALE_SHIFT=1, dut1 uses SCALE_SHIFT=0 for the saturation case;
//           sel routes the shared stimulus to one of them, the other stays idle.
module tb_mha_qk_score;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned D_H    = 4;
    localparam int unsigned N_TOK  = 8;
    localparam int unsigned OUT_W  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset_n;
    logic                     sel;
    logic                     init;
    logic [3:0]               n_tok;
    logic                     q_valid;
    logic signed [DATA_W-1:0] q_data;
    logic                     k_valid;
    logic signed [DATA_W-1:0] k_data;
    logic                     z_ready;

    mha_qk_score_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .N_TOK(N_TOK)) if0 ();
    mha_qk_score_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .N_TOK(N_TOK)) if1 ();

    assign if0.init    = !sel && init;
    assign if0.n_tok   = n_tok;
    assign if0.q_valid = !sel && q_valid;
    assign if0.q_data  = q_data;
    assign if0.k_valid = !sel && k_valid;
    assign if0.k_data  = k_data;
    assign if0.z_ready = sel ? 1'b1 : z_ready;

    assign if1.init    = sel && init;
    assign if1.n_tok   = n_tok;
    assign if1.q_valid = sel && q_valid;
    assign if1.q_data  = q_data;
    assign if1.k_valid = sel && k_valid;
    assign if1.k_data  = k_data;
    assign if1.z_ready = sel ? z_ready : 1'b1;

    mha_qk_score #(.DATA_W(DATA_W), .D_H(D_H), .N_TOK(N_TOK), .OUT_W(OUT_W), .SCALE_SHIFT(1))
        dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
    mha_qk_score #(.DATA_W(DATA_W), .D_H(D_H), .N_TOK(N_TOK), .OUT_W(OUT_W), .SCALE_SHIFT(0))
        dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));

    logic                    m_ready, m_done, m_q_ready, m_k_ready, m_z_valid, m_z_last;
    logic signed [OUT_W-1:0] m_z_data;
    assign m_ready   = sel ? if1.ready   : if0.ready;
    assign m_done    = sel ? if1.done    : if0.done;
    assign m_q_ready = sel ? if1.q_ready : if0.q_ready;
    assign m_k_ready = sel ? if1.k_ready : if0.k_ready;
    assign m_z_valid = sel ? if1.z_valid : if0.z_valid;
    assign m_z_last  = sel ? if1.z_last  : if0.z_last;
    assign m_z_data  = sel ? if1.z_data  : if0.z_data;

    int     n_vec = 0;
    int     n_err = 0;
    longint exp_z[$];
    bit     exp_last[$];
    int     q_vec[4];
    int     k_mat[8][4];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference score: exact dot product, floor shift, clamp to 16-bit signed.
    function automatic longint model_score(input int q[4], input int k[4], input int sh);
        longint dot;
        dot = 0;
        for (int i = 0; i < 4; i++) dot += longint'(q[i]) * longint'(k[i]);
        dot = dot >>> sh;
        if (dot > 32767) dot = 32767;
        else if (dot < -32768) dot = -32768;
        return dot;
    endfunction

    // Score checker: every Z handshake must match the next modelled score.
    always @(negedge clk) begin
        if (reset_n && m_z_valid && z_ready) begin
            if (exp_z.size() == 0) begin
                check("z_unexpected", 1, 0);
            end else begin
                check("z_data", longint'(m_z_data), exp_z.pop_front());
                check("z_last", longint'(m_z_last), longint'(exp_last.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_q_ready();
        int b;
        b = 0;
        while (!m_q_ready && b < 100) begin tick(); b++; end
        if (!m_q_ready) check("q_ready_timeout", 0, 1);
    endtask

    task automatic wait_k_ready();
        int b;
        b = 0;
        while (!m_k_ready && b < 100) begin tick(); b++; end
        if (!m_k_ready) check("k_ready_timeout", 0, 1);
    endtask

    task automatic send_q_row();
        for (int i = 0; i < 4; i++) begin
            q_valid = 1'b1;
            q_data  = 8'(q_vec[i]);
            wait_q_ready();
            tick();
        end
        q_valid = 1'b0;
    endtask

    task automatic start_pass(input int n_req);
        check("ready_before_init", longint'(m_ready), 1);
        init  = 1'b1;
        n_tok = 4'(n_req);
        tick();
        init  = 1'b0;
    endtask

    // One complete pass: model expectations queued first, then stimulus with timing checks.
    task automatic run_pass(input int n_req, input int sh, input int gap, input int stall,
                            input bit poke_init);
        int n;
        int kr[4];
        n = (n_req > 8) ? 8 : n_req;
        for (int r = 0; r < n; r++) begin
            for (int e = 0; e < 4; e++) kr[e] = k_mat[r][e];
            exp_z.push_back(model_score(q_vec, kr, sh));
            exp_last.push_back(r == n - 1);
        end
        start_pass(n_req);
        if (n == 0) begin
            check("zero_done", longint'(m_done), 1);
            check("zero_q_ready", longint'(m_q_ready), 0);
            check("zero_z_valid", longint'(m_z_valid), 0);
            tick();
            check("zero_ready", longint'(m_ready), 1);
            check("zero_done_clear", longint'(m_done), 0);
            return;
        end
        check("q_ready_after_init", longint'(m_q_ready), 1);
        send_q_row();
        check("k_ready_after_q", longint'(m_k_ready), 1);
        for (int r = 0; r < n; r++) begin
            for (int e = 0; e < 4; e++) begin
                if (gap > 0) begin
                    k_valid = 1'b0;
                    repeat ($urandom_range(0, gap)) tick();
                end
                init    = poke_init && (r == 0) && (e == 2);
                k_valid = 1'b1;
                k_data  = 8'(k_mat[r][e]);
                wait_k_ready();
                tick();
                init    = 1'b0;
            end
            k_valid = 1'b0;
            check("z_valid_after_k", longint'(m_z_valid), 1);
            if (stall > 0 && r == 0) begin
                z_ready = 1'b0;
                repeat (stall) begin
                    check("stall_z_valid", longint'(m_z_valid), 1);
                    check("stall_z_data", longint'(m_z_data), 5);
                    check("stall_k_ready", longint'(m_k_ready), 0);
                    tick();
                end
                z_ready = 1'b1;
            end
        end
        tick();
        check("done_pulse", longint'(m_done), 1);
        tick();
        check("done_clear", longint'(m_done), 0);
        check("ready_after_pass", longint'(m_ready), 1);
        check("scores_drained", longint'(exp_z.size()), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   longint'(m_ready), 1);
        check({tag, "_done"},    longint'(m_done), 0);
        check({tag, "_q_ready"}, longint'(m_q_ready), 0);
        check({tag, "_k_ready"}, longint'(m_k_ready), 0);
        check({tag, "_z_valid"}, longint'(m_z_valid), 0);
        check({tag, "_z_last"},  longint'(m_z_last), 0);
        check({tag, "_z_data"},  longint'(m_z_data), 0);
    endtask

    task automatic load_basic();
        q_vec    = '{1, 2, 3, 4};
        k_mat[0] = '{1, 1, 1, 1};
        k_mat[1] = '{-1, 0, 0, 0};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int qa[4];
        int ka[4];
        reset_n = 1'b0;
        sel     = 1'b0;
        init    = 1'b0;
        n_tok   = '0;
        q_valid = 1'b0;
        q_data  = '0;
        k_valid = 1'b0;
        k_data  = '0;
        z_ready = 1'b1;
        repeat (2) tick();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        tick();

        // Hand-computed pins on the reference model.
        qa = '{1, 2, 3, 4};
        ka = '{1, 1, 1, 1};
        check("model_basic0", model_score(qa, ka, 1), 5);
        ka = '{-1, 0, 0, 0};
        check("model_floor", model_score(qa, ka, 1), -1);
        qa = '{127, 127, 127, 127};
        ka = '{127, 127, 127, 127};
        check("model_sat_hi", model_score(qa, ka, 0), 32767);
        ka = '{-128, -128, -128, -128};
        check("model_sat_lo", model_score(qa, ka, 0), -32768);

        // Basic pass.
        load_basic();
        run_pass(2, 1, 0, 0, 1'b0);

        // Saturation on the unscaled instance.
        sel = 1'b1;
        tick();
        q_vec    = '{127, 127, 127, 127};
        k_mat[0] = '{127, 127, 127, 127};
        k_mat[1] = '{-128, -128, -128, -128};
        run_pass(2, 0, 0, 0, 1'b0);
        sel = 1'b0;
        tick();

        // Z backpressure on the first score plus random K gaps.
        load_basic();
        run_pass(2, 1, 3, 5, 1'b0);

        // Zero rows.
        run_pass(0, 1, 0, 0, 1'b0);

        // Over-range row count clamps to 8.
        q_vec = '{3, -5, 7, -2};
        for (int r = 0; r < 8; r++)
            for (int e = 0; e < 4; e++)
                k_mat[r][e] = ((r * 7 + e * 13) % 41) - 20;
        run_pass(15, 1, 1, 0, 1'b0);

        // init during MAC must be ignored.
        load_basic();
        run_pass(2, 1, 0, 0, 1'b1);

        // Reset after two K beats of row 0, then a fresh pass.
        load_basic();
        start_pass(2);
        send_q_row();
        for (int e = 0; e < 2; e++) begin
            k_valid = 1'b1;
            k_data  = 8'(k_mat[0][e]);
            wait_k_ready();
            tick();
        end
        k_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
        reset_n = 1'b1;
        tick();
        k_mat[0] = '{2, 2, 2, 2};
        k_mat[1] = '{0, 0, 0, -1};
        run_pass(2, 1, 0, 0, 1'b0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
